display_scan_driver: RTL and testbench

- Drives the segment decoder of the 4-digit calculator display.
- Accepts a binary magnitude plus sign through a load handshake and converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Time-multiplexes the digits onto the shared digit/enable bus at a fixed refresh rate.
- Also produces the answer flag that the decoder uses to suppress the decimal point.

---
 rtl/display_scan_driver.sv | 173 +++++++++++++++++
 tb/tb_display_scan_driver.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_driver
// Description : Converts a signed binary magnitude into four BCD digits with a
//               sequential shift-add-3 engine and time-multiplexes them onto
//               the shared digit/enable bus of the 4-digit display.
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int VALUE_W     = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [VALUE_W-1:0] value,
  input  logic               negative,
  input  logic               ans_sel,
  input  logic               load,
  output logic               busy,
  output logic [3:0]         digit,
  output logic [3:0]         enable,
  output logic               show_ans
);

  localparam int c_scan_w = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int c_cnt_w  = (VALUE_W > 2) ? $clog2(VALUE_W) : 1;

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_shift  = 2'd1;
  localparam logic [1:0] c_commit = 2'd2;

  localparam logic [c_scan_w-1:0] c_scan_last = c_scan_w'(REFRESH_DIV - 1);
  localparam logic [c_cnt_w-1:0]  c_bit_last  = c_cnt_w'(VALUE_W - 1);

  logic [1:0]          r_state;
  logic [1:0]          w_state_next;

  logic                w_accept;
  logic                w_shift;
  logic                w_commit;

  logic [VALUE_W-1:0]  w_mag;
  logic [15:0]         w_bcd_adj;

  logic [VALUE_W-1:0]  r_operand;
  logic [15:0]         r_bcd;
  logic [c_cnt_w-1:0]  r_bitcnt;
  logic                r_neg;
  logic                r_ans;

  logic [15:0]         r_disp;
  logic                r_show_ans;
  logic [c_scan_w-1:0] r_scan_cnt;
  logic [1:0]          r_scan_idx;
  logic [3:0]          r_digit;
  logic [3:0]          r_enable;

  // Clamp the magnitude to what four display positions can show (one is
  // spent on the dash for negative values). Comparisons are done at 32 bits
  // so narrow VALUE_W settings never see a truncated threshold.
  always_comb begin
    w_mag = value;
    if (negative && (32'(value) > 32'd999)) begin
      w_mag = VALUE_W'(999);
    end else if (!negative && (32'(value) > 32'd9999)) begin
      w_mag = VALUE_W'(9999);
    end
  end

  // Add-3 correction on every BCD nibble that is 5 or more before the shift.
  for (genvar g = 0; g < 4; g++) begin : g_nibble
    assign w_bcd_adj[g*4 +: 4] = (r_bcd[g*4 +: 4] >= 4'd5) ?
                                 (r_bcd[g*4 +: 4] + 4'd3) : r_bcd[g*4 +: 4];
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic: one SHIFT cycle per operand bit, then one COMMIT.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_idle:   if (load) w_state_next = c_shift;
      c_shift:  if (r_bitcnt == c_bit_last) w_state_next = c_commit;
      c_commit: w_state_next = c_idle;
      default:  w_state_next = c_idle;
    endcase
  end

  // FSM outputs: strobes for the datapath and the busy flag.
  always_comb begin
    w_accept = 1'b0;
    w_shift  = 1'b0;
    w_commit = 1'b0;
    busy     = 1'b0;
    case (r_state)
      c_idle:   w_accept = load;
      c_shift:  begin w_shift = 1'b1;  busy = 1'b1; end
      c_commit: begin w_commit = 1'b1; busy = 1'b1; end
      default:  ;
    endcase
  end

  // Conversion datapath: latch on accept, double-dabble while shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_operand <= '0;
      r_bcd     <= '0;
      r_bitcnt  <= '0;
      r_neg     <= 1'b0;
      r_ans     <= 1'b0;
    end else if (w_accept) begin
      r_operand <= w_mag;
      r_bcd     <= '0;
      r_bitcnt  <= '0;
      r_neg     <= negative;
      r_ans     <= ans_sel;
    end else if (w_shift) begin
      r_bcd     <= (w_bcd_adj << 1) | 16'(r_operand[VALUE_W-1]);
      r_operand <= r_operand << 1;
      r_bitcnt  <= r_bitcnt + 1'b1;
    end
  end

  // Display registers change only at COMMIT, so the bus never shows partial BCD.
  // A nonzero negative value gets the dash (code 10) in the leftmost position;
  // the clamp guarantees that position is otherwise zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp     <= '0;
      r_show_ans <= 1'b0;
    end else if (w_commit) begin
      r_disp     <= (r_neg && (r_bcd != 16'd0)) ? {4'd10, r_bcd[11:0]} : r_bcd;
      r_show_ans <= r_ans;
    end
  end

  // Free-running refresh counter; each wrap advances the lit position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_scan_idx <= 2'd0;
    end else if (r_scan_cnt == c_scan_last) begin
      r_scan_cnt <= '0;
      r_scan_idx <= r_scan_idx + 2'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  // Digit and anode select registered together so they always change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digit  <= 4'd0;
      r_enable <= 4'b1110;
    end else begin
      r_digit  <= r_disp[{r_scan_idx, 2'b00} +: 4];
      r_enable <= ~(4'b0001 << r_scan_idx);
    end
  end

  assign digit    = r_digit;
  assign enable   = r_enable;
  assign show_ans = r_show_ans;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scan_driver
// Description : Randomized self-checking bench for display_scan_driver with a
//               decimal-arithmetic reference model of the displayed value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan_driver;

  localparam int REFRESH_DIV = 4;
  localparam int VALUE_W     = 14;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [VALUE_W-1:0] value = '0;
  logic               negative = 1'b0;
  logic               ans_sel = 1'b0;
  logic               load = 1'b0;
  logic               busy;
  logic [3:0]         digit;
  logic [3:0]         enable;
  logic               show_ans;

  int          n_checks = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  logic [15:0] cur_exp = 16'h0000;
  logic        cur_ans = 1'b0;
  bit          hold_known = 1'b1;

  display_scan_driver #(
    .REFRESH_DIV (REFRESH_DIV),
    .VALUE_W     (VALUE_W)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .value    (value),
    .negative (negative),
    .ans_sel  (ans_sel),
    .load     (load),
    .busy     (busy),
    .digit    (digit),
    .enable   (enable),
    .show_ans (show_ans)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected display {pos3,pos2,pos1,pos0} from decimal arithmetic on the value.
  function automatic logic [15:0] model(input int v, input bit neg);
    int m;
    int d3;
    m = v;
    if (neg && m > 999) m = 999;
    if (!neg && m > 9999) m = 9999;
    d3 = (neg && m != 0) ? 10 : (m / 1000) % 10;
    return {4'(d3), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  function automatic int pos_of(input logic [3:0] e);
    case (e)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // Bus invariants checked on every cycle once the DUT has been reset.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("onehot", 32'($countones(~enable)), 32'd1);
      chk("digit_range", 32'(digit <= 4'd10), 32'd1);
    end
  end

  // Watch one full scan period and collect the digit shown at each position.
  task automatic read_disp(output logic [15:0] d);
    int p;
    d = 16'hFFFF;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4 * REFRESH_DIV; i++) begin
      @(negedge clk);
      p = pos_of(enable);
      if (p >= 0) d[p*4 +: 4] = digit;
    end
  endtask

  // Load one value, time busy, optionally poke load mid-conversion, then read back.
  task automatic convert(input int v, input bit neg, input bit ans,
                         input int inject_at, input string tag);
    int cnt;
    int p;
    int rerise;
    logic [15:0] got;
    @(negedge clk);
    value = VALUE_W'(v);
    negative = neg;
    ans_sel = ans;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    value = VALUE_W'($urandom_range(0, 16383));
    negative = 1'($urandom);
    ans_sel = 1'($urandom);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      if (hold_known) begin
        p = pos_of(enable);
        if (p >= 0) chk({tag, "_hold_digit"}, 32'(digit), 32'(cur_exp[p*4 +: 4]));
        chk({tag, "_hold_ans"}, 32'(show_ans), 32'(cur_ans));
      end
      if (cnt == inject_at) begin
        value = VALUE_W'(42);
        negative = 1'b0;
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      cnt++;
      @(negedge clk);
    end
    load = 1'b0;
    chk({tag, "_busy_len"}, 32'(cnt), 32'(VALUE_W + 1));
    if (inject_at >= 0) begin
      rerise = 0;
      repeat (20) begin
        @(negedge clk);
        if (busy !== 1'b0) rerise++;
      end
      chk({tag, "_no_rerise"}, 32'(rerise), 32'd0);
    end
    cur_exp = model(v, neg);
    cur_ans = ans;
    hold_known = 1'b1;
    read_disp(got);
    chk({tag, "_disp"}, 32'(got), 32'(cur_exp));
    chk({tag, "_show_ans"}, 32'(show_ans), 32'(cur_ans));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Main stimulus sequence.
  initial begin
    logic [3:0]  prev;
    logic [15:0] got;
    int          run;
    int          cnt;
    bit          seen;

    // Reset state
    #1 rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_enable", 32'(enable), 32'hE);
      chk("rst_digit", 32'(digit), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_show_ans", 32'(show_ans), 32'd0);
    end
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Scan order and period with an all-zero display
    prev = enable;
    run = 1;
    seen = 1'b0;
    chk("scan_start", 32'(enable), 32'hE);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      chk("scan_digit0", 32'(digit), 32'd0);
      if (enable !== prev) begin
        chk("scan_order", 32'(enable), 32'({prev[2:0], prev[3]}));
        if (seen) chk("scan_period", 32'(run), 32'(REFRESH_DIV));
        seen = 1'b1;
        run = 1;
        prev = enable;
      end else begin
        run++;
      end
    end

    // Directed conversions, negatives and clamps
    convert(1234, 1'b0, 1'b1, -1, "basic");
    convert(57, 1'b1, 1'b0, -1, "neg57");
    convert(5000, 1'b1, 1'b1, -1, "neg_clamp");
    convert(16383, 1'b0, 1'b0, -1, "pos_clamp");
    convert(0, 1'b1, 1'b1, -1, "neg_zero");
    convert(9999, 1'b0, 1'b0, -1, "max_pos");
    convert(999, 1'b1, 1'b1, -1, "max_neg");

    // Random conversions
    for (int i = 0; i < 8; i++) begin
      convert(int'($urandom_range(0, 16383)), 1'($urandom), 1'($urandom), -1, "rand");
    end

    // Load while busy is ignored
    convert(1234, 1'b0, 1'b1, 5, "busy_load");

    // Reset in the middle of a conversion
    @(negedge clk);
    value = VALUE_W'(9876);
    negative = 1'b0;
    ans_sel = 1'b1;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 7) begin
      cnt++;
      @(negedge clk);
    end
    chk("abort_reach", 32'(cnt), 32'd7);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_digit", 32'(digit), 32'd0);
    chk("abort_enable", 32'(enable), 32'hE);
    chk("abort_show_ans", 32'(show_ans), 32'd0);
    cur_exp = 16'h0000;
    cur_ans = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    read_disp(got);
    chk("abort_disp", 32'(got), 32'h0000);
    convert(9876, 1'b0, 1'b1, -1, "after_abort");

    // Random load traffic with the bus invariants watched every cycle
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) begin
        value = VALUE_W'($urandom_range(0, 16383));
        negative = 1'($urandom);
        ans_sel = 1'($urandom);
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
    end
    load = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk("rand_idle", 32'(busy), 32'd0);
    hold_known = 1'b0;
    convert(int'($urandom_range(0, 16383)), 1'($urandom), 1'b1, -1, "final_rand");
    convert(305, 1'b1, 1'b0, -1, "final_neg");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
